// File: rtl/lsu_pkg.sv
// Shared types and constants for the pipelined load/store unit.
package lsu_pkg;

    localparam int LSU_ADDR_W_EXT = 16;
    localparam int LSU_MAX_DATA_W = 64;

    typedef enum logic {
        INIT,
        RUN
    } lsu_state_e;

    // Widest response record; per-instance logic carries only DATA_W bits of rdata.
    typedef struct packed {
        logic [LSU_MAX_DATA_W-1:0] rdata;
        logic                      err;
        logic                      is_write;
    } lsu_rsp_t;

    function automatic logic addr_in_range(input logic [LSU_ADDR_W_EXT-1:0] addr,
                                           input int unsigned               addr_w);
        return (addr >> addr_w) == '0;
    endfunction

endpackage

// File: rtl/lsu_pipe_if.sv
// Request/response channel between the execute stage (master) and the LSU (slave).
interface lsu_pipe_if #(
    parameter int DATA_W = 16
);
    import lsu_pkg::*;

    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [LSU_ADDR_W_EXT-1:0] req_addr;
    logic [DATA_W-1:0]         req_wdata;
    logic [DATA_W/8-1:0]       req_be;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic                      rsp_is_write;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_is_write
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_is_write
    );

endinterface

// File: rtl/lsu_rsp_fifo.sv
// Synchronous FIFO of arbitrary depth (pointers wrap modulo DEPTH), exposing its fill count.
module lsu_rsp_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             pop_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && (count != '0);

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; only the pointers and count decide which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr] <= push_data;
    end

    assign pop_data = slots[rd_ptr];

endmodule

// File: rtl/lsu_pipe.sv
// Pipelined load/store unit: word RAM with byte-lane stores, fixed read latency,
// credit-limited in-order responses and a post-reset clear sweep.
module lsu_pipe
    import lsu_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int RD_LATENCY = 1,
    parameter int RSP_DEPTH  = RD_LATENCY + 2
) (
    input  logic       clk,
    input  logic       reset_n,
    lsu_pipe_if.slave  bus,
    output logic       busy
);

    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int BE_W   = DATA_W / 8;
    localparam int CNT_W  = $clog2(RSP_DEPTH + 1);

    // Width-specific view of lsu_rsp_t.
    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
        logic              is_write;
    } rsp_t;

    lsu_state_e        state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [CNT_W-1:0]  outstanding;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              accept;
    logic              pop;
    logic              in_range;
    logic              st_commit;
    logic [ADDR_W-1:0] word_idx;
    rsp_t              new_rsp;

    logic              pipe_vld [RD_LATENCY];
    rsp_t              pipe_rsp [RD_LATENCY];

    rsp_t              head;
    logic [CNT_W-1:0]  fifo_count;

    assign in_range  = addr_in_range(bus.req_addr, ADDR_W);
    assign word_idx  = bus.req_addr[ADDR_W-1:0];
    assign accept    = bus.req_valid && bus.req_ready;
    assign st_commit = accept && bus.req_write && in_range;
    assign pop       = bus.rsp_valid && bus.rsp_ready;

    // Credit check covers both pipeline stages and FIFO, so the FIFO can never overflow.
    assign bus.req_ready = (state == RUN) && (outstanding < CNT_W'(RSP_DEPTH));
    assign busy          = (state == INIT) || (outstanding != '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= INIT;
            clr_ptr <= '0;
        end else if (state == INIT) begin
            clr_ptr <= clr_ptr + 1'b1;
            if (&clr_ptr) state <= RUN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            outstanding <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // The INIT sweep owns the write port; stores can only arrive in RUN.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[clr_ptr] <= '0;
        end else if (st_commit) begin
            for (int i = 0; i < BE_W; i++) begin
                if (bus.req_be[i]) mem[word_idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
            end
        end
    end

    // NOTE: every field gets a default before the conditional so no latch is inferred.
    always_comb begin
        new_rsp          = '0;
        new_rsp.err      = !in_range;
        new_rsp.is_write = bus.req_write;
        if (!bus.req_write && in_range) new_rsp.rdata = mem[word_idx];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RD_LATENCY; i++) pipe_vld[i] <= 1'b0;
        end else begin
            pipe_vld[0] <= accept;
            for (int i = 1; i < RD_LATENCY; i++) pipe_vld[i] <= pipe_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (accept) pipe_rsp[0] <= new_rsp;
        for (int i = 1; i < RD_LATENCY; i++) pipe_rsp[i] <= pipe_rsp[i-1];
    end

    lsu_rsp_fifo #(
        .WIDTH ($bits(rsp_t)),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (pipe_vld[RD_LATENCY-1]),
        .push_data (pipe_rsp[RD_LATENCY-1]),
        .pop       (pop),
        .pop_data  (head),
        .count     (fifo_count)
    );

    // Idle outputs are forced to zero so nothing stale from the un-reset storage leaks out.
    assign bus.rsp_valid    = (fifo_count != '0);
    assign bus.rsp_rdata    = bus.rsp_valid ? head.rdata : '0;
    assign bus.rsp_err      = bus.rsp_valid && head.err;
    assign bus.rsp_is_write = bus.rsp_valid && head.is_write;

endmodule
